mul_div_unit: RTL

- Multi-cycle multiply/divide unit for the MIPS core, companion to the combinational ALU in the EX stage.
- Executes MULT/MULTU/DIV/DIVU iteratively, owns the architectural HI/LO registers and services MTHI/MTLO writes.
- The pipeline reads HI/LO directly for MFHI/MFLO and stalls on busy.
- Parametrised in datapath width; adds a start/busy/done handshake, cancel and defined divide-by-zero results.

---
 rtl/mul_div_unit_pkg.sv | 39 +++
 rtl/md_sign_fix.sv | 36 +++
 rtl/mul_div_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: ISA funct codes and
// helpers that classify a funct field.
package mul_div_unit_pkg;

  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MD_NONE,
    MD_MULDIV,
    MD_MOVE
  } md_class_e;

  function automatic md_class_e md_classify(input logic [5:0] funct);
    md_class_e cls;
    case (funct)
      FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU: cls = MD_MULDIV;
      FUN_MTHI, FUN_MTLO:                     cls = MD_MOVE;
      FUN_MFHI, FUN_MFLO:                     cls = MD_NONE;
      default:                                cls = MD_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic md_is_signed(input logic [5:0] funct);
    return (funct == FUN_MULT) || (funct == FUN_DIV);
  endfunction

  function automatic logic md_is_div(input logic [5:0] funct);
    return (funct == FUN_DIV) || (funct == FUN_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Turns the magnitude result of the iterative core into the architectural
// HI/LO values: negates product/quotient and signs the remainder.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic                 sign_a,
  input  logic                 sign_b,
  input  logic                 b_zero,
  input  logic [2*WIDTH-1:0]   mag,
  output logic [WIDTH-1:0]     hi_fix,
  output logic [WIDTH-1:0]     lo_fix
);

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;

  always_comb begin
    prod_s = mag;
    quo_s  = mag[WIDTH-1:0];
    rem_s  = mag[2*WIDTH-1:WIDTH];
    hi_fix = '0;
    lo_fix = '0;
    if (is_div) begin
      // A zero divisor keeps the all-ones quotient regardless of dividend sign.
      lo_fix = ((sign_a ^ sign_b) && !b_zero) ? -quo_s : quo_s;
      hi_fix = sign_a ? -rem_s : rem_s;
    end else begin
      prod_s = (sign_a ^ sign_b) ? -prod_s : prod_s;
      hi_fix = prod_s[2*WIDTH-1:WIDTH];
      lo_fix = prod_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one
// shift-add or shift-subtract step per cycle, then a sign-fix cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [5:0]       mdFunct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  if ((WIDTH < 8) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("mul_div_unit: WIDTH must be even and at least 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e               state, state_nxt;
  md_class_e            cls;
  logic                 load, iter, fix_wr, mt_wr;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div_q, sign_a_q, sign_b_q, b_zero_q;
  logic                 ld_signed, ld_div, ld_sa, ld_sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, rem_sh;
  logic [WIDTH-1:0]     div_rem;
  logic                 div_ge;
  logic [WIDTH-1:0]     hi_fix, lo_fix;

  assign cls  = md_classify(mdFunct);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Cancel beats any start; a new start beats the running iteration.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mt_wr     = 1'b0;
    fix_wr    = 1'b0;
    iter      = 1'b0;
    if (cancel) begin
      state_nxt = IDLE;
    end else if (start && cls == MD_MULDIV) begin
      state_nxt = RUN;
      load      = 1'b1;
    end else if (start && cls == MD_MOVE) begin
      state_nxt = IDLE;
      mt_wr     = 1'b1;
    end else begin
      case (state)
        RUN: begin
          iter = 1'b1;
          if (cnt == '0) state_nxt = FIX;
        end
        FIX: begin
          fix_wr    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ld_signed = md_is_signed(mdFunct);
    ld_div    = md_is_div(mdFunct);
    ld_sa     = ld_signed & opA[WIDTH-1];
    ld_sb     = ld_signed & opB[WIDTH-1];
    mag_a     = ld_sa ? -opA : opA;
    mag_b     = ld_sb ? -opB : opB;
  end

  // One step: multiply adds the multiplicand into the upper half and shifts
  // right; divide shifts the {rem,quo} pair left and trial-subtracts.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, opnd});
    div_rem  = div_ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
    acc_step = is_div_q ? {div_rem, acc[WIDTH-2:0], div_ge}
                        : {mul_sum, acc[WIDTH-1:1]};
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div (is_div_q),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .b_zero (b_zero_q),
    .mag    (acc),
    .hi_fix (hi_fix),
    .lo_fix (lo_fix)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= fix_wr;
      if (load) begin
        cnt      <= CNT_W'(WIDTH - 1);
        is_div_q <= ld_div;
        sign_a_q <= ld_sa;
        sign_b_q <= ld_sb;
        b_zero_q <= (opB == '0);
        acc      <= ld_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        opnd     <= ld_div ? mag_b : mag_a;
      end else if (iter) begin
        cnt <= cnt - CNT_W'(1);
        acc <= acc_step;
      end
      if (mt_wr) begin
        if (mdFunct == FUN_MTHI) hi <= opA;
        else                     lo <= opA;
      end
      if (fix_wr) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetN && start && !cancel && cls == MD_NONE)
      $warning("mul_div_unit: start with unsupported funct %h ignored", mdFunct);
  end
`endif

endmodule
